// File: rtl/wb_stage_param_if.sv
// MEM -> WB stage bus: instruction fields from MEM, regfile write port and status back out.
// The forwarding ports exist only when WB_FWD_EN is defined.
interface wb_stage_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSRC   = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic                   in_valid;
  logic                   flush;
  logic [NSRC*DATA_W-1:0] in_src;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_we;
  logic [REG_AW-1:0]      in_rd;
  logic [1:0]             in_ld_size;
  logic                   in_ld_sign;
  logic [1:0]             in_addr_lo;
  logic                   rf_we;
  logic [REG_AW-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   wb_valid;
  logic                   wb_misalign;
  logic [CNT_W-1:0]       retire_cnt;
`ifdef WB_FWD_EN
  logic                   fwd_valid;
  logic [REG_AW-1:0]      fwd_rd;
  logic [DATA_W-1:0]      fwd_data;
`endif

  modport master (
    output in_valid, flush, in_src, in_sel, in_we, in_rd, in_ld_size, in_ld_sign, in_addr_lo,
    input  rf_we, rf_waddr, rf_wdata, wb_valid, wb_misalign, retire_cnt
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport slave (
    input  in_valid, flush, in_src, in_sel, in_we, in_rd, in_ld_size, in_ld_sign, in_addr_lo,
    output rf_we, rf_waddr, rf_wdata, wb_valid, wb_misalign, retire_cnt
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/wb_stage_param.sv
// MEM/WB writeback stage: source select, sub-word load alignment, regfile write port, retire counter.
// Optional WB_FWD_EN adds a one-deep write history exposed on fwd_valid/fwd_rd/fwd_data.
module wb_stage_param #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSRC    = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned MEM_SRC = 1,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 32
) (
  input logic              clk,
  input logic              rst,
  wb_stage_param_if.slave  bus
);

  logic              accept;
  logic              is_mem;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] wdata_new;
  logic [31:0]       low_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  logic              rf_we_d,       rf_we_q;
  logic [REG_AW-1:0] rf_waddr_d,    rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_d,    rf_wdata_q;
  logic              wb_valid_d,    wb_valid_q;
  logic              wb_misalign_d, wb_misalign_q;
  logic [CNT_W-1:0]  retire_cnt_d,  retire_cnt_q;

  assign accept = bus.in_valid & ~bus.flush;
  assign is_mem = (32'(bus.in_sel) == MEM_SRC);

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(bus.in_sel) == i) sel_data = bus.in_src[i*DATA_W +: DATA_W];
    end
  end

  // Lanes are always taken from the low 32 bits, whatever DATA_W is.
  always_comb begin
    low_word  = sel_data[31:0];
    byte_v    = 8'(low_word >> {bus.in_addr_lo, 3'b000});
    half_v    = bus.in_addr_lo[1] ? low_word[31:16] : low_word[15:0];
    wdata_new = sel_data;
    if (is_mem) begin
      case (bus.in_ld_size)
        2'd0:    wdata_new = {{(DATA_W-8){bus.in_ld_sign & byte_v[7]}}, byte_v};
        2'd1:    wdata_new = {{(DATA_W-16){bus.in_ld_sign & half_v[15]}}, half_v};
        default: wdata_new = sel_data;
      endcase
    end
  end

  always_comb begin
    rf_we_d       = 1'b0;
    wb_valid_d    = 1'b0;
    wb_misalign_d = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    retire_cnt_d  = retire_cnt_q;
    if (accept) begin
      wb_valid_d    = 1'b1;
      rf_we_d       = bus.in_we & (|bus.in_rd);
      rf_waddr_d    = bus.in_rd;
      rf_wdata_d    = wdata_new;
      wb_misalign_d = is_mem & (bus.in_ld_size == 2'd1) & bus.in_addr_lo[0];
      retire_cnt_d  = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_misalign_q <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_misalign_q <= wb_misalign_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_misalign = wb_misalign_q;
  assign bus.retire_cnt  = retire_cnt_q;

`ifdef WB_FWD_EN
  logic              hist_valid_d, hist_valid_q;
  logic [REG_AW-1:0] hist_rd_d,    hist_rd_q;
  logic [DATA_W-1:0] hist_data_d,  hist_data_q;

  // Every write is remembered for exactly one cycle; a newer write replaces it, so a
  // same-rd write naturally invalidates the older history entry.
  always_comb begin
    hist_valid_d = rf_we_q;
    hist_rd_d    = hist_rd_q;
    hist_data_d  = hist_data_q;
    if (rf_we_q) begin
      hist_rd_d   = rf_waddr_q;
      hist_data_d = rf_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid_q <= 1'b0;
      hist_rd_q    <= '0;
      hist_data_q  <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_rd_q    <= hist_rd_d;
      hist_data_q  <= hist_data_d;
    end
  end

  assign bus.fwd_valid = rf_we_q | hist_valid_q;
  assign bus.fwd_rd    = rf_we_q ? rf_waddr_q : hist_rd_q;
  assign bus.fwd_data  = rf_we_q ? rf_wdata_q : hist_data_q;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: directed steps plus random traffic against an arithmetic reference model.
// Two instances: default build, and NSRC=3/CNT_W=4 for out-of-range select and counter wrap.
module tb_wb_stage_param;

  typedef struct packed {
    logic         v, fl, we, sign;
    logic [1:0]   sel, size, lo;
    logic [4:0]   rd;
    logic [127:0] src;
  } stim_t;

  typedef struct packed {
    logic        we, valid, mis;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_param_if #(.DATA_W(32), .NSRC(4), .SEL_W(2), .REG_AW(5), .CNT_W(32)) bus_a ();
  wb_stage_param_if #(.DATA_W(32), .NSRC(3), .SEL_W(2), .REG_AW(5), .CNT_W(4))  bus_b ();

  wb_stage_param #(.DATA_W(32), .NSRC(4), .SEL_W(2), .MEM_SRC(1), .REG_AW(5), .CNT_W(32))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  wb_stage_param #(.DATA_W(32), .NSRC(3), .SEL_W(2), .MEM_SRC(1), .REG_AW(5), .CNT_W(4))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int    errors = 0;
  int    checks = 0;
  stim_t sa, sb;
  exp_t  ea, eb, pa;
  logic  r, pr;

  function automatic logic [31:0] ref_data(stim_t s, int unsigned nsrc);
    int unsigned sel;
    logic [31:0] v;
    logic [7:0]  b8;
    logic [15:0] h16;
    sel = s.sel;
    if (sel >= nsrc) return '0;
    v = s.src[32*sel +: 32];
    if (sel != 1) return v;
    if (s.size == 2'd0) begin
      b8 = 8'((v >> (8 * s.lo)) & 32'hFF);
      return s.sign ? 32'(signed'(b8)) : 32'(b8);
    end
    if (s.size == 2'd1) begin
      h16 = 16'(v >> (16 * (s.lo / 2)));
      return s.sign ? 32'(signed'(h16)) : 32'(h16);
    end
    return v;
  endfunction

  function automatic exp_t model_step(exp_t e, stim_t s, int unsigned nsrc, int unsigned cnt_w, logic rs);
    exp_t n;
    if (rs) return '0;
    n       = e;
    n.we    = 1'b0;
    n.valid = 1'b0;
    n.mis   = 1'b0;
    if (s.v && !s.fl) begin
      n.valid = 1'b1;
      n.we    = s.we && (s.rd != 0);
      n.waddr = s.rd;
      n.wdata = ref_data(s, nsrc);
      n.mis   = (s.sel == 2'd1) && (s.size == 2'd1) && s.lo[0];
      n.cnt   = 32'((64'(e.cnt) + 64'd1) % (64'd1 << cnt_w));
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    rst              = r;
    bus_a.in_valid   = sa.v;   bus_a.flush      = sa.fl;  bus_a.in_src     = sa.src;
    bus_a.in_sel     = sa.sel; bus_a.in_we      = sa.we;  bus_a.in_rd      = sa.rd;
    bus_a.in_ld_size = sa.size; bus_a.in_ld_sign = sa.sign; bus_a.in_addr_lo = sa.lo;
    bus_b.in_valid   = sb.v;   bus_b.flush      = sb.fl;  bus_b.in_src     = sb.src[95:0];
    bus_b.in_sel     = sb.sel; bus_b.in_we      = sb.we;  bus_b.in_rd      = sb.rd;
    bus_b.in_ld_size = sb.size; bus_b.in_ld_sign = sb.sign; bus_b.in_addr_lo = sb.lo;
  endtask

  task automatic check_all();
    chk("a_rf_we",       bus_a.rf_we,       ea.we);
    chk("a_rf_waddr",    bus_a.rf_waddr,    ea.waddr);
    chk("a_rf_wdata",    bus_a.rf_wdata,    ea.wdata);
    chk("a_wb_valid",    bus_a.wb_valid,    ea.valid);
    chk("a_wb_misalign", bus_a.wb_misalign, ea.mis);
    chk("a_retire_cnt",  bus_a.retire_cnt,  ea.cnt);
    chk("b_rf_we",       bus_b.rf_we,       eb.we);
    chk("b_rf_wdata",    bus_b.rf_wdata,    eb.wdata);
    chk("b_wb_valid",    bus_b.wb_valid,    eb.valid);
    chk("b_retire_cnt",  bus_b.retire_cnt,  eb.cnt);
`ifdef WB_FWD_EN
    if (ea.we) begin
      chk("a_fwd_valid", bus_a.fwd_valid, 1);
      chk("a_fwd_rd",    bus_a.fwd_rd,    ea.waddr);
      chk("a_fwd_data",  bus_a.fwd_data,  ea.wdata);
    end else if (!pr && pa.we) begin
      chk("a_fwd_valid_hist", bus_a.fwd_valid, 1);
      chk("a_fwd_rd_hist",    bus_a.fwd_rd,    pa.waddr);
      chk("a_fwd_data_hist",  bus_a.fwd_data,  pa.wdata);
    end else begin
      chk("a_fwd_valid_off",  bus_a.fwd_valid, 0);
    end
`endif
  endtask

  task automatic tick();
    exp_t na, nb;
    apply();
    na = model_step(ea, sa, 4, 32, r);
    nb = model_step(eb, sb, 3, 4, r);
    @(posedge clk);
    #1;
    pa = ea;
    pr = r;
    ea = na;
    eb = nb;
    check_all();
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.v    = ($urandom_range(0, 4) != 0);
    s.fl   = ($urandom_range(0, 4) == 0);
    s.we   = ($urandom_range(0, 3) != 0);
    s.sign = 1'($urandom);
    s.sel  = 2'($urandom);
    s.size = 2'($urandom);
    s.lo   = 2'($urandom);
    s.rd   = 5'($urandom);
    s.src  = {$urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  initial begin
    ea = '0; eb = '0; pa = '0; pr = 1'b1;
    sa = rand_stim(); sb = rand_stim();

    // Reset with valid instructions presented.
    r = 1'b1; sa.v = 1'b1; sa.fl = 1'b0; sb.v = 1'b1; sb.fl = 1'b0;
    tick();
    tick();
    chk("reset_cnt_const", bus_a.retire_cnt, 0);
    chk("reset_we_const",  bus_a.rf_we, 0);

    // ALU write to r5.
    r = 1'b0; sb.v = 1'b0;
    sa = '0; sa.v = 1'b1; sa.we = 1'b1; sa.rd = 5'd5; sa.sel = 2'd0;
    sa.src[31:0] = 32'h1234_5678; sa.src[63:32] = 32'h80FF_7F01;
    tick();
    chk("alu_wdata_const", bus_a.rf_wdata, 32'h1234_5678);
    chk("alu_cnt_const",   bus_a.retire_cnt, 1);

    // Load alignment cases from the MEM source.
    sa.sel = 2'd1; sa.size = 2'd0; sa.sign = 1'b1; sa.lo = 2'd1;
    tick();
    chk("ld_b1s_const", bus_a.rf_wdata, 32'h0000_007F);
    sa.lo = 2'd3;
    tick();
    chk("ld_b3s_const", bus_a.rf_wdata, 32'hFFFF_FF80);
    sa.size = 2'd1; sa.sign = 1'b0; sa.lo = 2'd2;
    tick();
    chk("ld_h2z_const", bus_a.rf_wdata, 32'h0000_80FF);
    sa.lo = 2'd1;
    tick();
    chk("ld_h1_const",  bus_a.rf_wdata, 32'h0000_7F01);
    chk("ld_h1_mis",    bus_a.wb_misalign, 1);

    // r0 write suppressed; valid+flush is a bubble.
    sa.sel = 2'd0; sa.rd = 5'd0;
    tick();
    chk("rd0_we_const", bus_a.rf_we, 0);
    sa.rd = 5'd9; sa.fl = 1'b1;
    tick();
    chk("flush_cnt_const", bus_a.retire_cnt, 6);
    sa.fl = 1'b0; sa.v = 1'b0;

    // Out-of-range select on the 3-source build, then drive its 4-bit counter through the wrap.
    sb = '0; sb.v = 1'b1; sb.we = 1'b1; sb.rd = 5'd4; sb.sel = 2'd3; sb.src = {4{32'hDEAD_BEEF}};
    tick();
    chk("b_sel3_const", bus_b.rf_wdata, 0);
    for (int i = 0; i < 20 && eb.cnt != 32'd15; i++) begin
      sb.sel = 2'($urandom_range(0, 2));
      tick();
    end
    chk("b_cnt_at_max", bus_b.retire_cnt, 15);
    tick();
    chk("b_cnt_wrap_const", bus_b.retire_cnt, 0);
    sb.v = 1'b0;

    // Write to r7 followed by bubbles (history visible when forwarding is built in).
    sa = '0; sa.v = 1'b1; sa.we = 1'b1; sa.rd = 5'd7; sa.src[31:0] = 32'hCAFE_0007;
    tick();
    sa.v = 1'b0;
    tick();
    tick();
    tick();

    // Randomised traffic with occasional reset while instructions are captured.
    for (int i = 0; i < 400; i++) begin
      sa = rand_stim();
      sb = rand_stim();
      r  = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
